p4_adder: RTL and testbench
===========================

Name: p4_adder

Overview:
- Pentium-4-style parallel-prefix adder: a sparse-tree carry generator produces one carry every 4 bits, and a carry-select sum generator uses those carries.
- Produces a combinational sum/carry-out from A, B and CIN.
- Also provides a registered copy of sum/carry-out for synchronous sampling by the surrounding datapath and bench.
- Serves as the adder core of the datapath ALU.

Parameters:
- DWIDTH, 32, operand/sum width in bits; must be a multiple of 4 and at least 8.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset; clears registered outputs only
- A  input  DWIDTH  operand A
- B  input  DWIDTH  operand B
- CIN  input  1  carry-in
- S  output  DWIDTH  combinational sum, (A + B + CIN) mod 2^DWIDTH
- COUT  output  1  combinational carry-out, bit DWIDTH of A + B + CIN
- S_SYNC  output  DWIDTH  S registered on rising clk
- COUT_SYNC  output  1  COUT registered on rising clk

Behaviour:
- Interface: one clock domain (clk); reset rst is asynchronous and active-high.
- Combinational path (S, COUT):
  - Zero latency; no clock or reset dependence.
  - Outputs are purely a function of A, B and CIN.
- Carry generator:
  - Bitwise p = A^B and g = A&B.
  - CIN is folded into bit 0: g0' = g0 | (p0 & CIN).
  - Radix-2 sparse prefix tree emits carries C4, C8, …, C(DWIDTH).
  - C(DWIDTH) drives COUT.
- Sum generator, for block k of 4 bits:
  - Two ripple-carry adders, one with carry-in 0 and one with carry-in 1.
  - A 2:1 mux selects between them using C(4k); C0 = CIN.
- Arithmetic: unsigned modulo 2^DWIDTH.
  - Wrap-around: all-ones + 1 gives S = 0, COUT = 1.
  - No saturation.
- Registered path:
  - On each rising clk, S_SYNC <= S and COUT_SYNC <= COUT.
  - Latency is 1 cycle from input change to registered output.
- Reset:
  - While rst = 1, S_SYNC = 0 and COUT_SYNC = 0 immediately, independent of clk.
  - Release is synchronous in effect: the first rising clk with rst = 0 loads the current sum.
- Reset mid-operation:
  - Clears only the registered outputs.
  - S and COUT keep tracking the inputs.
- X/glitch:
  - S may glitch between input changes.
  - S_SYNC must be stable and correct whenever inputs have been stable for at least one setup time before the clk edge.

Optional Feature:
- Macro: P4_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output OVF (1 bit): signed two's-complement overflow, computed as C(DWIDTH) XOR carry into the MSB.
  - Adds output OVF_SYNC: OVF registered like S_SYNC, reset to 0.
- When undefined: neither port exists and the remaining behaviour is identical.

Test Plan:
- Reset: rst = 1 with A = 0xFFFFFFFF, B = 1 -> S_SYNC = 0, COUT_SYNC = 0 while reset held. S = 0 and COUT = 1 combinationally regardless of reset.
- Basic add: A = 0x00000005, B = 0x00000003, CIN = 0 -> S = 0x00000008, COUT = 0. S_SYNC shows 0x00000008 after the next rising clk.
- Carry-in and wrap: A = 0xFFFFFFFF, B = 0x00000000, CIN = 1 -> S = 0x00000000, COUT = 1.
- Block-boundary carry chain: A = 0x0FFFFFFF, B = 0x00000001, CIN = 0 -> S = 0x10000000, COUT = 0, exercising every sparse-tree carry.
- Overflow (with P4_OVERFLOW_FLAG_EN): A = 0x7FFFFFFF, B = 1 -> S = 0x80000000, OVF = 1, COUT = 0. A = 0x80000000, B = 0x80000000 -> S = 0, OVF = 1, COUT = 1.
- Random: 10000 random A/B/CIN, checked against reference A+B+CIN on the combinational outputs each cycle and on S_SYNC/COUT_SYNC one cycle later, including an asynchronous rst pulse mid-run.

Source files
------------

// File: rtl/p4_adder_if.sv
// Bus bundle for the p4_adder: operands, carry-in, combinational and registered results.
// P4_OVERFLOW_FLAG_EN adds the signed-overflow flags OVF / OVF_SYNC.
interface p4_adder_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] A;
  logic [DWIDTH-1:0] B;
  logic              CIN;
  logic [DWIDTH-1:0] S;
  logic              COUT;
  logic [DWIDTH-1:0] S_SYNC;
  logic              COUT_SYNC;
`ifdef P4_OVERFLOW_FLAG_EN
  logic              OVF;
  logic              OVF_SYNC;

  modport master (output A, B, CIN, input S, COUT, S_SYNC, COUT_SYNC, OVF, OVF_SYNC);
  modport slave  (input A, B, CIN, output S, COUT, S_SYNC, COUT_SYNC, OVF, OVF_SYNC);
`else
  modport master (output A, B, CIN, input S, COUT, S_SYNC, COUT_SYNC);
  modport slave  (input A, B, CIN, output S, COUT, S_SYNC, COUT_SYNC);
`endif
endinterface

// File: rtl/p4_adder.sv
// Pentium-4-style sparse-tree adder: one prefix carry per 4-bit block feeding carry-select sums.
// Optional macro P4_OVERFLOW_FLAG_EN adds signed overflow outputs OVF / OVF_SYNC.
module p4_adder #(
  parameter int DWIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  p4_adder_if.slave  bus
);
  localparam int NBLK = DWIDTH / 4;

  logic [DWIDTH-1:0] sum_s;
  logic [NBLK-1:0]   blk_cin_s;
  logic              cout_s;
  logic              ovf_s;

  logic [DWIDTH-1:0] s_q, s_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  // Returns {carry_out, sum[3:0]} of a 4-bit ripple-carry adder.
  function automatic logic [4:0] ripple4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic       c;
    logic [3:0] s;
    c = cin;
    s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
    end
    return {c, s};
  endfunction

  // Sparse carry tree: per-block group G/P, then radix-2 prefix over blocks.
  always_comb begin : carry_tree
    logic [DWIDTH-1:0] p_v, g_v;
    logic [NBLK-1:0]   gt, pt, gn, pn;
    logic              gg, pp;
    p_v = bus.A ^ bus.B;
    g_v = bus.A & bus.B;
    g_v[0] = g_v[0] | (p_v[0] & bus.CIN);
    gt = '0;
    pt = '0;
    for (int k = 0; k < NBLK; k++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int i = 0; i < 4; i++) begin
        gg = g_v[4*k+i] | (p_v[4*k+i] & gg);
        pp = pp & p_v[4*k+i];
      end
      gt[k] = gg;
      pt[k] = pp;
    end
    for (int d = 1; d < NBLK; d = d * 2) begin
      gn = gt;
      pn = pt;
      for (int k = d; k < NBLK; k++) begin
        gn[k] = gt[k] | (pt[k] & gt[k-d]);
        pn[k] = pt[k] & pt[k-d];
      end
      gt = gn;
      pt = pn;
    end
    // gt[k] is now C(4(k+1)); block 0 takes CIN directly.
    blk_cin_s = {gt[NBLK-2:0], bus.CIN};
    cout_s    = gt[NBLK-1];
  end

  // Carry-select sum: each block precomputes both carry-in cases and picks one.
  always_comb begin : sum_select
    logic [4:0] lo, hi;
    sum_s = '0;
    for (int k = 0; k < NBLK; k++) begin
      lo = ripple4(bus.A[4*k +: 4], bus.B[4*k +: 4], 1'b0);
      hi = ripple4(bus.A[4*k +: 4], bus.B[4*k +: 4], 1'b1);
      sum_s[4*k +: 4] = blk_cin_s[k] ? hi[3:0] : lo[3:0];
    end
  end

  // Overflow = carry out of MSB xor carry into MSB (recovered from the MSB sum bit).
  always_comb begin : ovf_calc
    ovf_s = cout_s ^ (bus.A[DWIDTH-1] ^ bus.B[DWIDTH-1] ^ sum_s[DWIDTH-1]);
  end

  // Next-state for the registered copy.
  always_comb begin : sync_next
    s_d    = sum_s;
    cout_d = cout_s;
    ovf_d  = ovf_s;
  end

  // Registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.S         = sum_s;
  assign bus.COUT      = cout_s;
  assign bus.S_SYNC    = s_q;
  assign bus.COUT_SYNC = cout_q;
`ifdef P4_OVERFLOW_FLAG_EN
  assign bus.OVF       = ovf_s;
  assign bus.OVF_SYNC  = ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s  = ovf_q;
`endif
endmodule

// File: tb/tb_p4_adder.sv
// Self-checking bench for p4_adder: directed corner cases plus random operands against plain arithmetic.
module tb_p4_adder;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  p4_adder_if #(.DWIDTH(W)) bus ();

  p4_adder #(.DWIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] r;
    r = ref_add(a, b, c);
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] r;
    r = ref_add(a, b, c);
    chk("S", {32'd0, bus.S}, {32'd0, r[W-1:0]});
    chk("COUT", {63'd0, bus.COUT}, {63'd0, r[W]});
`ifdef P4_OVERFLOW_FLAG_EN
    chk("OVF", {63'd0, bus.OVF}, {63'd0, ref_ovf(a, b, c)});
`endif
  endtask

  task automatic check_sync(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] r;
    r = ref_add(a, b, c);
    chk("S_SYNC", {32'd0, bus.S_SYNC}, {32'd0, r[W-1:0]});
    chk("COUT_SYNC", {63'd0, bus.COUT_SYNC}, {63'd0, r[W]});
`ifdef P4_OVERFLOW_FLAG_EN
    chk("OVF_SYNC", {63'd0, bus.OVF_SYNC}, {63'd0, ref_ovf(a, b, c)});
`endif
  endtask

  task automatic check_cleared();
    chk("S_SYNC_rst", {32'd0, bus.S_SYNC}, 64'd0);
    chk("COUT_SYNC_rst", {63'd0, bus.COUT_SYNC}, 64'd0);
`ifdef P4_OVERFLOW_FLAG_EN
    chk("OVF_SYNC_rst", {63'd0, bus.OVF_SYNC}, 64'd0);
`endif
  endtask

  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    bus.A   = a;
    bus.B   = b;
    bus.CIN = c;
    #1;
    check_comb(a, b, c);
    @(posedge clk);
    #1;
    check_sync(a, b, c);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.A   = 32'hFFFF_FFFF;
    bus.B   = 32'h0000_0001;
    bus.CIN = 1'b0;

    // Reset held: registered outputs clear, combinational path still live.
    #1;
    check_cleared();
    chk("S_in_rst", {32'd0, bus.S}, 64'd0);
    chk("COUT_in_rst", {63'd0, bus.COUT}, 64'd1);
    @(posedge clk);
    #1;
    check_cleared();
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    step(32'h0000_0005, 32'h0000_0003, 1'b0);
    chk("basic_S_SYNC", {32'd0, bus.S_SYNC}, 64'h0000_0008);
    step(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    chk("wrap_COUT_SYNC", {63'd0, bus.COUT_SYNC}, 64'd1);
    step(32'h0FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("chain_S_SYNC", {32'd0, bus.S_SYNC}, 64'h1000_0000);
    step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    step(32'h8000_0000, 32'h8000_0000, 1'b0);
    step(32'h0000_0000, 32'h0000_0000, 1'b0);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
`ifdef P4_OVERFLOW_FLAG_EN
    step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("ovf_pos", {63'd0, bus.OVF_SYNC}, 64'd1);
`endif

    // Random operands with an asynchronous reset pulse midway.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      step(ra, rb, rc);
      if (i == 5000) begin
        #1;
        rst = 1'b1;
        #1;
        check_cleared();
        check_comb(ra, rb, rc);
        #2;
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
